mips_16_core_top: RTL and testbench

MIPS_16_CORE_TOP -- requirements
Module: mips_16_core_top

---
 rtl/mips_16_core_top.sv | 248 ++++++++++++++++++++++++
 tb/tb_mips_16_core_top.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_16_core_top.sv
// 16-bit five-stage MIPS-like core (IF, ID, EX, MEM, WB) with RAW stalls.
// Define FORWARDING_EN to forward EX/MEM and MEM/WB results into EX.

module imem #(
    parameter int PC_WIDTH = 8,
    parameter int W        = 16
) (
    input  logic                clk,
    input  logic                load_en,
    input  logic [PC_WIDTH-1:0] load_addr,
    input  logic [W-1:0]        load_data,
    input  logic [PC_WIDTH-1:0] addr,
    output logic [W-1:0]        data
);
    logic [W-1:0] rom [0:(1<<PC_WIDTH)-1];

    // Boot-load port; tied off in this core, the image is preloaded.
    always_ff @(posedge clk) if (load_en) rom[load_addr] <= load_data;
    assign data = rom[addr];
endmodule

module IF_stage #(
    parameter int PC_WIDTH = 8,
    parameter int W        = 16
) (
    input  logic                clk,
    input  logic [PC_WIDTH-1:0] pc,
    output logic [W-1:0]        fetch_ir
);
    imem #(.PC_WIDTH(PC_WIDTH), .W(W)) imem (
        .clk(clk), .load_en(1'b0), .load_addr('0), .load_data('0),
        .addr(pc), .data(fetch_ir)
    );
endmodule

module dmem #(parameter int W = 16) (
    input  logic         clk,
    input  logic         we,
    input  logic [7:0]   addr,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata
);
    logic [W-1:0] ram [0:255];

    always_ff @(posedge clk) if (we) ram[addr] <= wdata;
    assign rdata = ram[addr];
endmodule

module MEM_stage #(parameter int W = 16) (
    input  logic         clk,
    input  logic         we,
    input  logic [7:0]   addr,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata
);
    dmem #(.W(W)) dmem (
        .clk(clk), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata)
    );
endmodule

module register_file #(parameter int W = 16) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [2:0]   waddr,
    input  logic [W-1:0] wdata,
    input  logic [2:0]   ra1,
    input  logic [2:0]   ra2,
    input  logic [2:0]   ra3,
    output logic [W-1:0] rd1,
    output logic [W-1:0] rd2,
    output logic [W-1:0] rd3
);
    logic [W-1:0] reg_array [0:7];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) reg_array[i] <= '0;
        end else if (we) begin
            reg_array[waddr] <= wdata;
        end
    end

    // WB write lands in the first half-cycle: ID sees it the same cycle.
    assign rd1 = (we && waddr == ra1) ? wdata : reg_array[ra1];
    assign rd2 = (we && waddr == ra2) ? wdata : reg_array[ra2];
    assign rd3 = (we && waddr == ra3) ? wdata : reg_array[ra3];
endmodule

module mips_16_core_top #(
    parameter int PC_WIDTH   = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    output logic [PC_WIDTH-1:0] pc
);
    localparam int W = DATA_WIDTH;

    typedef struct packed {
        logic [W-1:0]        ir;
        logic [PC_WIDTH-1:0] pc;
        logic [W-1:0]        a;
        logic [W-1:0]        b;
        logic [W-1:0]        d;
    } id_ex_t;

    typedef struct packed {
        logic [3:0]   op;
        logic         wr;
        logic [2:0]   rd;
        logic [W-1:0] res;
        logic [W-1:0] sd;
    } ex_mem_t;

    typedef struct packed {
        logic         wr;
        logic [2:0]   rd;
        logic [W-1:0] data;
    } mem_wb_t;

    logic [PC_WIDTH-1:0] pc_q, pc_d, ifid_pc_q, ifid_pc_d, target;
    logic [W-1:0]        ifid_ir_q, ifid_ir_d, fetch_ir, instruction;
    logic [W-1:0]        id_a, id_b, id_d, ram_rdata, mem_res;
    logic [W-1:0]        ex_a, ex_b, ex_d, ex_imm, alu;
    logic [3:0]          ex_op;
    logic [2:0]          ex_rd;
    logic                stall, taken;
    id_ex_t              idex_q, idex_d;
    ex_mem_t             exmem_q, exmem_d;
    mem_wb_t             memwb_q, memwb_d;

    function automatic logic writes_rd(input logic [3:0] op);
        return op inside {[4'd1:4'd10], 4'd12};
    endfunction

    function automatic logic reads_reg(input logic [W-1:0] ir, input logic [2:0] r);
        logic [3:0] op;
        op = ir[15:12];
        return (op inside {[4'd1:4'd11]} && ir[8:6] == r)
            || (op inside {[4'd1:4'd8]} && ir[5:3] == r)
            || (op inside {4'd11, 4'd12, 4'd14, 4'd15} && ir[11:9] == r);
    endfunction

    assign pc          = pc_q;
    assign instruction = ifid_ir_q;

    IF_stage #(.PC_WIDTH(PC_WIDTH), .W(W)) IF_stage_inst (
        .clk(clk), .pc(pc_q), .fetch_ir(fetch_ir)
    );

    register_file #(.W(W)) register_file_inst (
        .clk(clk), .rst(rst),
        .we(memwb_q.wr), .waddr(memwb_q.rd), .wdata(memwb_q.data),
        .ra1(ifid_ir_q[8:6]), .ra2(ifid_ir_q[5:3]), .ra3(ifid_ir_q[11:9]),
        .rd1(id_a), .rd2(id_b), .rd3(id_d)
    );

    MEM_stage #(.W(W)) MEM_stage_inst (
        .clk(clk), .we(exmem_q.op == 4'd11), .addr(exmem_q.res[7:0]),
        .wdata(exmem_q.sd), .rdata(ram_rdata)
    );

    assign ex_op   = idex_q.ir[15:12];
    assign ex_rd   = idex_q.ir[11:9];
    assign ex_imm  = W'(signed'(idex_q.ir[5:0]));
    assign mem_res = (exmem_q.op == 4'd10) ? ram_rdata : exmem_q.res;

`ifdef FORWARDING_EN
    function automatic logic [W-1:0] fwd(input logic [2:0] r, input logic [W-1:0] v);
        if (exmem_q.wr && exmem_q.rd == r) return mem_res;
        if (memwb_q.wr && memwb_q.rd == r) return memwb_q.data;
        return v;
    endfunction

    // Only a load's data arrives too late to forward into the next op.
    assign stall = ex_op == 4'd10 && reads_reg(ifid_ir_q, ex_rd);
`else
    assign stall = (writes_rd(ex_op) && reads_reg(ifid_ir_q, ex_rd))
                || (exmem_q.wr && reads_reg(ifid_ir_q, exmem_q.rd));
`endif

    always_comb begin
        ex_a = idex_q.a;
        ex_b = idex_q.b;
        ex_d = idex_q.d;
`ifdef FORWARDING_EN
        ex_a = fwd(idex_q.ir[8:6], idex_q.a);
        ex_b = fwd(idex_q.ir[5:3], idex_q.b);
        ex_d = fwd(idex_q.ir[11:9], idex_q.d);
`endif
        case (ex_op)
            4'd1:                alu = ex_a + ex_b;
            4'd2:                alu = ex_a - ex_b;
            4'd3:                alu = ex_a & ex_b;
            4'd4:                alu = ex_a | ex_b;
            4'd5:                alu = ex_a ^ ex_b;
            4'd6:                alu = ex_a << ex_b[3:0];
            4'd7:                alu = $signed(ex_a) >>> ex_b[3:0];
            4'd8:                alu = ex_a >> ex_b[3:0];
            4'd9, 4'd10, 4'd11:  alu = ex_a + ex_imm;
            4'd12:               alu = {idex_q.ir[7:0], ex_d[7:0]};
            default:             alu = '0;
        endcase
        taken  = (ex_op == 4'd13)
              || (ex_op == 4'd14 && ex_d == '0)
              || (ex_op == 4'd15 && ex_d != '0);
        target = idex_q.pc + PC_WIDTH'(1) + PC_WIDTH'(signed'(idex_q.ir[5:0]));
    end

    always_comb begin
        pc_d      = pc_q + PC_WIDTH'(1);
        ifid_ir_d = fetch_ir;
        ifid_pc_d = pc_q;
        idex_d    = '{ir: ifid_ir_q, pc: ifid_pc_q, a: id_a, b: id_b, d: id_d};
        if (taken) begin
            pc_d      = target;
            ifid_ir_d = '0;
            ifid_pc_d = '0;
            idex_d    = '0;
        end else if (stall) begin
            pc_d      = pc_q;
            ifid_ir_d = ifid_ir_q;
            ifid_pc_d = ifid_pc_q;
            idex_d    = '0;
        end
        exmem_d = '{op: ex_op, wr: writes_rd(ex_op), rd: ex_rd, res: alu, sd: ex_d};
        memwb_d = '{wr: exmem_q.wr, rd: exmem_q.rd, data: mem_res};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= '0;
            ifid_ir_q <= '0;
            ifid_pc_q <= '0;
            idex_q    <= '0;
            exmem_q   <= '0;
            memwb_q   <= '0;
        end else begin
            pc_q      <= pc_d;
            ifid_ir_q <= ifid_ir_d;
            ifid_pc_q <= ifid_pc_d;
            idex_q    <= idex_d;
            exmem_q   <= exmem_d;
            memwb_q   <= memwb_d;
        end
    end
endmodule

// File: tb/tb_mips_16_core_top.sv
// Bench for mips_16_core_top: directed programs plus random programs
// compared against an instruction-level model of the ISA.

module tb_mips_16_core_top;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pc;
    int         n_checks = 0;
    int         n_fail = 0;

    logic [15:0] prog  [0:255];
    logic [15:0] m_reg [0:7];
    logic [15:0] m_ram [0:255];

    mips_16_core_top dut (.clk(clk), .rst(rst), .pc(pc));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int imm6);
        return {4'(op), 3'(rd), 3'(rs1), 6'(imm6)};
    endfunction

    function automatic logic [15:0] enc_r(input int op, input int rd, input int rs1, input int rs2);
        return {4'(op), 3'(rd), 3'(rs1), 3'(rs2), 3'b000};
    endfunction

    function automatic logic [15:0] enc_lhi(input int rd, input int imm8);
        return {4'd12, 3'(rd), 1'b0, 8'(imm8)};
    endfunction

    function automatic logic [15:0] halt();
        return enc(13, 0, 0, -1);
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
    endtask

    task automatic start();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) dut.IF_stage_inst.imem.rom[i] = prog[i];
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] dreg(input int r);
        return dut.register_file_inst.reg_array[r];
    endfunction

    task automatic check_halt(input string tag, input int h);
        int hits;
        int outside;
        hits = 0;
        outside = 0;
        repeat (6) begin
            @(negedge clk);
            if (int'(pc) == h) hits++;
            else if (int'(pc) < h || int'(pc) > h + 2) outside++;
        end
        check(tag, (hits > 0 && outside == 0), 1);
    endtask

    // Instruction-level reference: executes prog from 0 until it hits halt_pc.
    task automatic iss(input int halt_pc);
        int p;
        int nx;
        int imi;
        logic [3:0]  op;
        logic [2:0]  rd;
        logic [15:0] ir, a, b;
        p = 0;
        for (int i = 0; i < 8; i++) m_reg[i] = 16'h0;
        for (int i = 0; i < 256; i++) m_ram[i] = 16'h0;
        for (int s = 0; s < 5000 && p != halt_pc; s++) begin
            ir  = prog[p];
            op  = ir[15:12];
            rd  = ir[11:9];
            a   = m_reg[ir[8:6]];
            b   = m_reg[ir[5:3]];
            imi = ir[5] ? int'(ir[5:0]) - 64 : int'(ir[5:0]);
            nx  = p + 1;
            case (op)
                4'd1:  m_reg[rd] = a + b;
                4'd2:  m_reg[rd] = a - b;
                4'd3:  m_reg[rd] = a & b;
                4'd4:  m_reg[rd] = a | b;
                4'd5:  m_reg[rd] = a ^ b;
                4'd6:  m_reg[rd] = a << b[3:0];
                4'd7:  m_reg[rd] = 16'($signed(a) >>> b[3:0]);
                4'd8:  m_reg[rd] = a >> b[3:0];
                4'd9:  m_reg[rd] = a + 16'(imi);
                4'd10: m_reg[rd] = m_ram[8'(a + 16'(imi))];
                4'd11: m_ram[8'(a + 16'(imi))] = m_reg[rd];
                4'd12: m_reg[rd] = {ir[7:0], m_reg[rd][7:0]};
                4'd13: nx = p + 1 + imi;
                4'd14: if (m_reg[rd] == 16'h0) nx = p + 1 + imi;
                4'd15: if (m_reg[rd] != 16'h0) nx = p + 1 + imi;
                default: ;
            endcase
            p = nx & 255;
        end
    endtask

    // Prologue zeroes ram[0..15]; body keeps R0 at zero so loads/stores stay there.
    task automatic gen_random();
        int op, rd, rs1, rs2, imm;
        clear_prog();
        for (int k = 0; k < 16; k++) prog[k] = enc(11, 0, 0, k);
        for (int i = 16; i < 40; i++) begin
            op  = $urandom_range(0, 15);
            rd  = $urandom_range(1, 7);
            rs1 = $urandom_range(0, 7);
            rs2 = $urandom_range(0, 7);
            case (op)
                9:          prog[i] = enc(9, rd, rs1, $urandom_range(0, 63));
                10, 11:     prog[i] = enc(op, rd, 0, $urandom_range(0, 15));
                12:         prog[i] = enc_lhi(rd, $urandom_range(0, 255));
                13, 14, 15: begin
                    imm = $urandom_range(0, 3);
                    if (imm > 39 - i) imm = 39 - i;
                    prog[i] = enc(op, rd, 0, imm);
                end
                default:    prog[i] = enc_r(op, rd, rs1, rs2);
            endcase
        end
        prog[40] = halt();
    endtask

    initial begin
        int seq [5];
        seq = '{1, 2, 3, 4, 6};

        #1 rst = 1'b0;
        #3;
        check("rst_pc", pc, 0);
        check("rst_instr", dut.instruction, 0);
        for (int r = 0; r < 8; r++) check($sformatf("rst_r%0d", r), dreg(r), 0);

        clear_prog();
        prog[0] = enc(9, 1, 0, 5);
        prog[1] = enc(9, 2, 0, 7);
        start();
        run(20);
        for (int r = 0; r < 8; r++)
            check($sformatf("addi_r%0d", r), dreg(r), (r == 1) ? 5 : (r == 2) ? 7 : 0);

        clear_prog();
        prog[0] = enc(9, 1, 0, 10);
        prog[1] = enc(11, 1, 0, 10);
        prog[2] = enc(10, 4, 0, 10);
        prog[3] = halt();
        start();
        run(50);
        check("st_ram10", dut.MEM_stage_inst.dmem.ram[10], 10);
        check("ld_r4", dreg(4), 10);

        clear_prog();
        prog[2] = enc(13, 0, 0, 3);
        for (int k = 3; k <= 5; k++) prog[k] = enc(9, 5, 0, 1);
        prog[6] = halt();
        start();
        check("ram_kept_by_rst", dut.MEM_stage_inst.dmem.ram[10], 10);
        check("br_pc0", pc, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("br_pc%0d", k + 1), pc, seq[k]);
        end
        run(30);
        check("br_r5", dreg(5), 0);

        clear_prog();
        prog[0] = enc(9, 1, 0, 1);
        prog[1] = enc_r(1, 2, 1, 1);
        prog[2] = enc_r(1, 3, 2, 2);
        prog[3] = halt();
        start();
        run(40);
        check("raw_r2", dreg(2), 2);
        check("raw_r3", dreg(3), 4);

        clear_prog();
        prog[0] = enc(9, 1, 0, 5);
        prog[1] = enc(9, 2, 0, 7);
        prog[2] = enc_r(1, 3, 3, 1);
        prog[3] = enc(9, 2, 2, -1);
        prog[4] = enc(15, 2, 0, -3);
        prog[5] = halt();
        start();
        run(400);
        check("mul_r3", dreg(3), 35);
        check_halt("mul_halt", 5);

        start();
        run(40);
        #2 rst = 1'b0;
        #1;
        check("async_pc", pc, 0);
        check("async_instr", dut.instruction, 0);
        for (int r = 0; r < 8; r++) check($sformatf("async_r%0d", r), dreg(r), 0);
        @(negedge clk);
        @(negedge clk);
        check("async_hold_pc", pc, 0);
        rst = 1'b1;
        run(400);
        check("restart_r3", dreg(3), 35);
        check("restart_r2", dreg(2), 0);
        check_halt("restart_halt", 5);

        for (int t = 0; t < 8; t++) begin
            gen_random();
            iss(40);
            start();
            run(300);
            for (int r = 0; r < 8; r++)
                check($sformatf("rnd%0d_r%0d", t, r), dreg(r), m_reg[r]);
            for (int a = 0; a < 16; a++)
                check($sformatf("rnd%0d_ram%0d", t, a), dut.MEM_stage_inst.dmem.ram[a], m_ram[a]);
            check_halt($sformatf("rnd%0d_halt", t), 40);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
